// File: rtl/psum_pass_sequencer.sv
// Pass sequencer for one layer: fetches an input tile, fires every macro, gathers
// their done pulses and hands a first/last-tagged psum strobe to the partial-sum adder.
module psum_pass_sequencer #(
   parameter int MACRO_NUM = 4,
   parameter int PASS_NUM  = 9,
   parameter int PIX_W     = 16,
   parameter int TO_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [PIX_W-1:0]     pix_total,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [MACRO_NUM-1:0] macro_start,
   input  logic [MACRO_NUM-1:0] macro_done,
   output logic                 psum_valid,
   output logic                 psum_first,
   output logic                 psum_last,
   output logic [PIX_W-1:0]     pix_cnt,
   output logic                 busy,
   output logic                 layer_done,
   output logic                 timeout_err
);

   localparam int PASS_W = (PASS_NUM > 1) ? $clog2(PASS_NUM) : 1;
   localparam int WAIT_W = $clog2(TO_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                state_q;
   logic [PASS_W-1:0]     pass_cnt_q;
   logic [PIX_W-1:0]      pix_cnt_q;
   logic [PIX_W-1:0]      pix_total_q;
   logic [MACRO_NUM-1:0]  done_seen_q;
   logic [WAIT_W-1:0]     wait_cnt_q;
   logic                  in_ready_q;
   logic [MACRO_NUM-1:0]  macro_start_q;
   logic                  psum_valid_q;
   logic                  psum_first_q;
   logic                  psum_last_q;
   logic                  busy_q;
   logic                  layer_done_q;
   logic                  timeout_err_q;

   logic [MACRO_NUM-1:0]  done_merged_d;
   logic                  all_done_d;
   logic [WAIT_W-1:0]     wait_inc_d;
   logic                  last_pass_d;
   logic                  last_pix_d;

   // A done pulse arriving in the same cycle as the final missing bit still completes the pass.
   assign done_merged_d = done_seen_q | macro_done;
   assign all_done_d    = &done_merged_d;
   assign wait_inc_d    = wait_cnt_q + WAIT_W'(1);
   assign last_pass_d   = (pass_cnt_q == PASS_W'(PASS_NUM - 1));
   assign last_pix_d    = (pix_cnt_q == (pix_total_q - PIX_W'(1)));

   // Every output is registered: each transition loads the values the next state presents.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         pass_cnt_q    <= '0;
         pix_cnt_q     <= '0;
         pix_total_q   <= '0;
         done_seen_q   <= '0;
         wait_cnt_q    <= '0;
         in_ready_q    <= 1'b0;
         macro_start_q <= '0;
         psum_valid_q  <= 1'b0;
         psum_first_q  <= 1'b0;
         psum_last_q   <= 1'b0;
         busy_q        <= 1'b0;
         layer_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         macro_start_q <= '0;
         psum_valid_q  <= 1'b0;
         psum_first_q  <= 1'b0;
         psum_last_q   <= 1'b0;
         layer_done_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  timeout_err_q <= 1'b0;
                  busy_q        <= 1'b1;
                  if (pix_total != '0) begin
                     pix_total_q <= pix_total;
                     pix_cnt_q   <= '0;
                     pass_cnt_q  <= '0;
                     done_seen_q <= '0;
                     wait_cnt_q  <= '0;
                     in_ready_q  <= 1'b1;
                     state_q     <= S_FETCH;
                  end else begin
                     layer_done_q <= 1'b1;
                     state_q      <= S_DONE;
                  end
               end
            end

            S_FETCH: begin
               if (in_valid) begin
                  in_ready_q    <= 1'b0;
                  macro_start_q <= '1;
                  state_q       <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               done_seen_q <= '0;
               wait_cnt_q  <= '0;
               state_q     <= S_WAIT;
            end

            S_WAIT: begin
               done_seen_q <= done_merged_d;
               if (all_done_d) begin
                  psum_valid_q <= 1'b1;
                  psum_first_q <= (pass_cnt_q == '0);
                  psum_last_q  <= last_pass_d;
                  state_q      <= S_EMIT;
               end else begin
                  wait_cnt_q <= wait_inc_d;
                  if (wait_inc_d == WAIT_W'(TO_CYCLES)) begin
                     timeout_err_q <= 1'b1;
                     busy_q        <= 1'b0;
                     state_q       <= S_IDLE;
                  end
               end
            end

            S_EMIT: begin
               if (!last_pass_d) begin
                  pass_cnt_q <= pass_cnt_q + PASS_W'(1);
                  in_ready_q <= 1'b1;
                  state_q    <= S_FETCH;
               end else begin
                  pass_cnt_q <= '0;
                  pix_cnt_q  <= pix_cnt_q + PIX_W'(1);
                  if (last_pix_d) begin
                     layer_done_q <= 1'b1;
                     state_q      <= S_DONE;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= S_FETCH;
                  end
               end
            end

            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               busy_q     <= 1'b0;
               in_ready_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign macro_start = macro_start_q;
   assign psum_valid  = psum_valid_q;
   assign psum_first  = psum_first_q;
   assign psum_last   = psum_last_q;
   assign pix_cnt     = pix_cnt_q;
   assign busy        = busy_q;
   assign layer_done  = layer_done_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_psum_pass_sequencer.sv
// Bench for psum_pass_sequencer: randomized layers checked against pass/pixel-level expectations.
module tb_psum_pass_sequencer;

   localparam int MN    = 4;
   localparam int PN    = 3;
   localparam int PW    = 16;
   localparam int TO    = 64;
   localparam int ALL1  = (1 << MN) - 1;

   logic          clk;
   logic          rstn;
   logic          start;
   logic [PW-1:0] pix_total;
   logic          in_valid;
   logic          in_ready;
   logic [MN-1:0] macro_start;
   logic [MN-1:0] macro_done;
   logic          psum_valid;
   logic          psum_first;
   logic          psum_last;
   logic [PW-1:0] pix_cnt;
   logic          busy;
   logic          layer_done;
   logic          timeout_err;

   int checks = 0;
   int errors = 0;

   // Per-pass done schedule: offset (cycles after macro_start) of each macro's pulse, 0 = never.
   int tdone[MN];
   int tdup[MN];

   psum_pass_sequencer #(
      .MACRO_NUM(MN), .PASS_NUM(PN), .PIX_W(PW), .TO_CYCLES(TO)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .pix_total(pix_total),
      .in_valid(in_valid), .in_ready(in_ready), .macro_start(macro_start),
      .macro_done(macro_done), .psum_valid(psum_valid), .psum_first(psum_first),
      .psum_last(psum_last), .pix_cnt(pix_cnt), .busy(busy),
      .layer_done(layer_done), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},    32'(in_ready),    0);
      check({tag, "_macro_start"}, 32'(macro_start), 0);
      check({tag, "_psum_valid"},  32'(psum_valid),  0);
      check({tag, "_psum_first"},  32'(psum_first),  0);
      check({tag, "_psum_last"},   32'(psum_last),   0);
      check({tag, "_pix_cnt"},     32'(pix_cnt),     0);
      check({tag, "_busy"},        32'(busy),        0);
      check({tag, "_layer_done"},  32'(layer_done),  0);
      check({tag, "_timeout_err"}, 32'(timeout_err), 0);
   endtask

   // kind: 0 all at +3, 1 random with duplicates, 2 staggered, 3 macro2 never, 4 macro3 at +TO
   task automatic set_pattern(input int kind);
      for (int m = 0; m < MN; m++) begin
         tdone[m] = int'($urandom_range(1, 8));
         tdup[m]  = ($urandom_range(0, 1) == 1) ? tdone[m] + int'($urandom_range(1, 4)) : 0;
      end
      case (kind)
         0: for (int m = 0; m < MN; m++) begin tdone[m] = 3; tdup[m] = 0; end
         2: begin
            tdone[0] = 1; tdup[0] = 0;
            tdone[1] = 2; tdup[1] = 4;
            tdone[2] = 3; tdup[2] = 0;
            tdone[3] = 7; tdup[3] = 0;
         end
         3: begin tdone[2] = 0; tdup[2] = 0; end
         4: tdone[3] = TO;
         default: ;
      endcase
   endtask

   task automatic start_layer(input int n);
      start     = 1'b1;
      pix_total = PW'(n);
      @(negedge clk);
      start     = 1'b0;
      pix_total = PW'($urandom);
      check("start_busy",        32'(busy),        1);
      check("start_in_ready",    32'(in_ready),    1);
      check("start_timeout_clr", 32'(timeout_err), 0);
      check("start_pix_cnt",     32'(pix_cnt),     0);
   endtask

   // Enters at a negedge where FETCH is visible; leaves one cycle after EMIT, or in IDLE after abort.
   task automatic run_pass(input int x, input int p, input int gap, output bit timed_out);
      logic [MN-1:0] mask;
      bit            complete;
      int            tmax;
      int            lim;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         check("fetch_ready_hold", 32'(in_ready),    1);
         check("fetch_no_start",   32'(macro_start), 0);
         check("fetch_no_timeout", 32'(timeout_err), 0);
         @(negedge clk);
      end
      check("fetch_ready",   32'(in_ready), 1);
      check("pass_pix_cnt",  32'(pix_cnt),  32'(x));
      in_valid = 1'b1;
      @(negedge clk);
      check("issue_macro_start", 32'(macro_start), ALL1);
      check("issue_ready_low",   32'(in_ready),    0);
      in_valid   = 1'($urandom_range(0, 1));
      macro_done = MN'($urandom);
      @(negedge clk);
      check("wait_start_low", 32'(macro_start), 0);

      complete = 1'b1;
      tmax     = 0;
      for (int m = 0; m < MN; m++) begin
         if (tdone[m] == 0) complete = 1'b0;
         if (tdone[m] > tmax) tmax = tdone[m];
      end
      lim = complete ? tmax : TO;
      for (int k = 1; k <= lim; k++) begin
         mask = '0;
         for (int m = 0; m < MN; m++)
            if (tdone[m] == k || tdup[m] == k) mask[m] = 1'b1;
         macro_done = mask;
         start      = 1'($urandom_range(0, 1));
         pix_total  = PW'($urandom);
         @(negedge clk);
         if (k == 1) check("wait_busy", 32'(busy), 1);
         if (k == lim && complete) begin
            check("emit_valid", 32'(psum_valid), 1);
            check("emit_first", 32'(psum_first), 32'(p == 0));
            check("emit_last",  32'(psum_last),  32'(p == PN - 1));
         end else begin
            check("wait_no_valid", 32'(psum_valid), 0);
            check("wait_no_first", 32'(psum_first), 0);
            if (k == lim - 1) check("wait_no_early_timeout", 32'(timeout_err), 0);
         end
      end
      start      = 1'b0;
      macro_done = '0;
      in_valid   = 1'b0;
      timed_out  = !complete;
      if (complete) begin
         @(negedge clk);
         check("emit_one_cycle", 32'(psum_valid), 0);
      end else begin
         check("abort_timeout_err", 32'(timeout_err), 1);
         check("abort_busy_low",    32'(busy),        0);
         check("abort_no_done",     32'(layer_done),  0);
      end
   endtask

   // Runs a whole layer; pass number 'special' (flattened) uses 'skind' and a 20-cycle fetch stall.
   task automatic run_layer(input int npix, input int kind, input int special, input int skind);
      bit to;
      int flat;
      start_layer(npix);
      for (int x = 0; x < npix; x++) begin
         for (int p = 0; p < PN; p++) begin
            flat = x * PN + p;
            set_pattern(flat == special ? skind : kind);
            run_pass(x, p, flat == special ? 20 : (kind == 0 ? 0 : int'($urandom_range(0, 4))), to);
            if (to) return;
            if (x == npix - 1 && p == PN - 1) begin
               check("layer_done_pulse", 32'(layer_done), 1);
               check("layer_done_busy",  32'(busy),       1);
               @(negedge clk);
               check("after_done_low",   32'(layer_done), 0);
               check("after_done_idle",  32'(busy),       0);
               check("after_done_ready", 32'(in_ready),   0);
            end else begin
               check("mid_layer_no_done", 32'(layer_done), 0);
            end
         end
      end
   endtask

   initial begin
      bit to;
      rstn       = 1'b0;
      start      = 1'b0;
      pix_total  = '0;
      in_valid   = 1'b0;
      macro_done = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rstn = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);

      // two pixels, fixed done latency, no input stalls
      run_layer(2, 0, -1, 0);
      // random layer with one staggered pass behind a long fetch stall
      run_layer(3, 1, 4, 2);
      // last done arriving on the final allowed wait cycle
      run_layer(1, 1, 2, 4);

      // empty layer
      start     = 1'b1;
      pix_total = '0;
      @(negedge clk);
      start     = 1'b0;
      pix_total = PW'($urandom);
      check("empty_busy",       32'(busy),        1);
      check("empty_done",       32'(layer_done),  1);
      check("empty_no_start",   32'(macro_start), 0);
      check("empty_no_ready",   32'(in_ready),    0);
      @(negedge clk);
      check("empty_idle",       32'(busy),        0);
      check("empty_done_low",   32'(layer_done),  0);
      check("empty_no_valid",   32'(psum_valid),  0);

      // timeout on pass 3, then sticky error until the next start
      run_layer(2, 1, 3, 3);
      repeat (3) begin
         @(negedge clk);
         check("timeout_sticky",  32'(timeout_err), 1);
         check("timeout_idle",    32'(busy),        0);
         check("timeout_no_psum", 32'(psum_valid),  0);
      end
      run_layer(1, 1, -1, 0);

      // reset while pixel 1 is waiting on macros
      start_layer(2);
      for (int p = 0; p < PN; p++) begin
         set_pattern(1);
         run_pass(0, p, 0, to);
      end
      check("rst_pix1_cnt", 32'(pix_cnt), 1);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid   = 1'b0;
      @(negedge clk);
      macro_done = 4'b0011;
      @(negedge clk);
      macro_done = '0;
      #2 rstn = 1'b0;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      check_all_zero("reset_held");
      rstn = 1'b1;
      @(negedge clk);
      run_layer(1, 1, -1, 0);

      repeat (3) run_layer(int'($urandom_range(1, 3)), 1, -1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
